noc_client_rx: RTL and testbench

Endpoint receive block for a NoC client. It sits at the client end of a switch output port's `noc_if` (the `tx` side of a `t_switch_top` port) and terminates the credit-based virtual-channel protocol. It buffers arriving packets per VC and returns one credit per drained packet. Buffered packets are presented to the client logic through a single valid/ready stream with round-robin arbitration across VCs. It also flags protocol violations: overflow, misrouted packets, and multi-hot VC targets.

---
 rtl/noc_client_rx.sv | 172 +++++++++++++++++
 tb/tb_noc_client_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_client_rx.sv
// Receive endpoint for a credit-based virtual-channel NoC port: per-VC packet
// FIFOs, round-robin valid/ready output stream, credit return and error flags.

package noc_client_rx_pkg;
    localparam int DEFAULT_D_W           = 8;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
endpackage

module noc_client_rx
    import noc_client_rx_pkg::*;
#(
    parameter int N             = 2,
    parameter int A_W           = $clog2(N) + 1,
    parameter int D_W           = DEFAULT_D_W,
    parameter int posx          = 0,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [VC_W-1:0]                            in_vc_target,
    input  logic [A_W+D_W-1:0]                         in_packet,
    output logic [VC_W-1:0]                            in_vc_credit_gnt,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [((VC_W > 1) ? $clog2(VC_W) : 1)-1:0] out_vc,
    output logic [D_W-1:0]                             out_data,
    output logic                                       err_overflow,
    output logic                                       err_addr,
    output logic                                       err_onehot,
    output logic [31:0]                                rx_count
);

    localparam int VC_IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam int PTR_W    = (VC_FIFO_DEPTH > 1) ? $clog2(VC_FIFO_DEPTH) : 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(VC_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [D_W-1:0]      mem_q    [VC_W][VC_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q [VC_W];
    logic [PTR_W-1:0]    wr_ptr_d [VC_W];
    logic [PTR_W-1:0]    rd_ptr_q [VC_W];
    logic [PTR_W-1:0]    rd_ptr_d [VC_W];
    logic [VC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [VC_IDX_W-1:0] lock_vc_q, lock_vc_d;
    logic                lock_q, lock_d;
    logic [VC_W-1:0]     credit_q, credit_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_addr_q, err_addr_d;
    logic                err_onehot_q, err_onehot_d;
    logic [31:0]         rx_count_q, rx_count_d;

    logic [VC_W-1:0]     nonempty, full;
    logic [VC_IDX_W-1:0] rr_pick, grant, push_vc;
    logic                tgt_any, tgt_multi, push_ok, overflow, pop;
    logic [A_W-1:0]      pkt_dst;
    logic [D_W-1:0]      pkt_payload;

    assign pkt_dst     = in_packet[A_W+D_W-1:D_W];
    assign pkt_payload = in_packet[D_W-1:0];

    // One slot is always left free, so equal pointers unambiguously mean empty.
    always_comb begin
        for (int v = 0; v < VC_W; v++) begin
            nonempty[v] = (wr_ptr_q[v] != rd_ptr_q[v]);
            full[v]     = (ptr_inc(wr_ptr_q[v]) == rd_ptr_q[v]);
        end
    end

    always_comb begin : rr_search
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        rr_pick = rr_ptr_q;
        for (int i = 0; i < VC_W; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= VC_W) idx = idx - VC_W;
            if (!found && nonempty[VC_IDX_W'(idx)]) begin
                found   = 1'b1;
                rr_pick = VC_IDX_W'(idx);
            end
        end
    end

    // A stalled grant stays put even if an earlier VC in round-robin order fills.
    assign grant     = lock_q ? lock_vc_q : rr_pick;
    assign out_valid = |nonempty;
    assign out_vc    = grant;
    assign out_data  = mem_q[grant][rd_ptr_q[grant]];
    assign pop       = out_valid && out_ready;

    always_comb begin
        push_vc = '0;
        for (int v = 0; v < VC_W; v++) begin
            if (in_vc_target[v]) push_vc = VC_IDX_W'(v);
        end
        tgt_any   = |in_vc_target;
        tgt_multi = tgt_any && ((in_vc_target & (in_vc_target - VC_W'(1))) != '0);
        push_ok   = tgt_any && !tgt_multi &&
                    (!full[push_vc] || (pop && (grant == push_vc)));
        overflow  = tgt_any && !tgt_multi && !push_ok;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d[push_vc] = ptr_inc(wr_ptr_q[push_vc]);
        if (pop)     rd_ptr_d[grant]   = ptr_inc(rd_ptr_q[grant]);

        rr_ptr_d = rr_ptr_q;
        credit_d = '0;
        if (pop) begin
            rr_ptr_d        = (grant == VC_IDX_W'(VC_W - 1)) ? '0 : grant + VC_IDX_W'(1);
            credit_d[grant] = 1'b1;
        end

        lock_d    = out_valid && !out_ready;
        lock_vc_d = grant;

        err_overflow_d = overflow;
        err_addr_d     = push_ok && (pkt_dst != A_W'(posx));
        err_onehot_d   = tgt_multi;
        rx_count_d     = rx_count_q + (push_ok ? 32'd1 : 32'd0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < VC_W; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
            rr_ptr_q       <= '0;
            lock_q         <= 1'b0;
            lock_vc_q      <= '0;
            credit_q       <= '0;
            err_overflow_q <= 1'b0;
            err_addr_q     <= 1'b0;
            err_onehot_q   <= 1'b0;
            rx_count_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_q         <= lock_d;
            lock_vc_q      <= lock_vc_d;
            credit_q       <= credit_d;
            err_overflow_q <= err_overflow_d;
            err_addr_q     <= err_addr_d;
            err_onehot_q   <= err_onehot_d;
            rx_count_q     <= rx_count_d;
        end
    end

    // NOTE: packet storage is deliberately not reset; the pointers alone define
    // which entries are valid, so resetting the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[push_vc][wr_ptr_q[push_vc]] <= pkt_payload;
    end

    assign in_vc_credit_gnt = credit_q;
    assign err_overflow     = err_overflow_q;
    assign err_addr         = err_addr_q;
    assign err_onehot       = err_onehot_q;
    assign rx_count         = rx_count_q;

endmodule

// File: tb/tb_noc_client_rx.sv
// Self-checking bench for noc_client_rx: queue-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.

module tb_noc_client_rx;

    localparam int VC_W  = 2;
    localparam int D_W   = 8;
    localparam int A_W   = 2;
    localparam int DEPTH = 4;
    localparam int POSX  = 0;
    localparam int MB    = 16;

    logic            clk;
    logic            rst;
    logic [VC_W-1:0] in_vc_target;
    logic [A_W+D_W-1:0] in_packet;
    logic [VC_W-1:0] in_vc_credit_gnt;
    logic            out_valid;
    logic            out_ready;
    logic [0:0]      out_vc;
    logic [D_W-1:0]  out_data;
    logic            err_overflow, err_addr, err_onehot;
    logic [31:0]     rx_count;

    noc_client_rx #(
        .N(2), .A_W(A_W), .D_W(D_W), .posx(POSX), .VC_W(VC_W), .VC_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vc_target(in_vc_target), .in_packet(in_packet),
        .in_vc_credit_gnt(in_vc_credit_gnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vc(out_vc), .out_data(out_data),
        .err_overflow(err_overflow), .err_addr(err_addr), .err_onehot(err_onehot),
        .rx_count(rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: one plain FIFO (head index + count) per VC.
    logic [7:0]      m_buf [VC_W][MB];
    int              m_head [VC_W];
    int              m_cnt  [VC_W];
    int              m_rr;
    bit              m_held;
    int              m_held_vc;
    logic [VC_W-1:0] m_credit;
    bit              m_eo, m_ea, m_eh;
    logic [31:0]     m_rx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_pick();
        if (m_held) return m_held_vc;
        for (int i = 0; i < VC_W; i++) begin
            int v;
            v = (m_rr + i) % VC_W;
            if (m_cnt[v] > 0) return v;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [1:0] tgt, input logic [1:0] dst,
                                input logic [7:0] data, input logic rdy, input logic r);
        int v, pv, nb;
        bit pop;
        if (!r) begin
            for (int i = 0; i < VC_W; i++) begin
                m_head[i] = 0;
                m_cnt[i]  = 0;
            end
            m_rr = 0; m_held = 1'b0; m_held_vc = 0; m_credit = '0;
            m_eo = 1'b0; m_ea = 1'b0; m_eh = 1'b0; m_rx = '0;
            return;
        end
        v   = m_pick();
        pop = (v >= 0) && rdy;
        nb  = $countones(tgt);
        m_eo = 1'b0; m_ea = 1'b0; m_eh = (nb > 1);
        m_credit = '0;
        if (pop) begin
            m_credit[v] = 1'b1;
            m_head[v]   = (m_head[v] + 1) % MB;
            m_cnt[v]--;
        end
        if (nb == 1) begin
            pv = 0;
            for (int i = 0; i < VC_W; i++) if (tgt[i]) pv = i;
            if (m_cnt[pv] < DEPTH - 1) begin
                m_buf[pv][(m_head[pv] + m_cnt[pv]) % MB] = data;
                m_cnt[pv]++;
                m_rx++;
                m_ea = (dst != POSX);
            end else begin
                m_eo = 1'b1;
            end
        end
        m_held    = (v >= 0) && !rdy;
        m_held_vc = v;
        if (pop) m_rr = (v + 1) % VC_W;
    endtask

    task automatic drive(input logic [1:0] tgt, input logic [1:0] dst,
                         input logic [7:0] data, input logic rdy, input logic r);
        in_vc_target = tgt;
        in_packet    = {dst, data};
        out_ready    = rdy;
        rst          = r;
        model_update(tgt, dst, data, rdy, r);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int v;
            v = m_pick();
            check("out_valid", out_valid, v >= 0);
            if (v >= 0) begin
                check("out_vc", out_vc, v);
                check("out_data", out_data, m_buf[v][m_head[v]]);
            end
            check("credit", in_vc_credit_gnt, m_credit);
            check("err_overflow", err_overflow, m_eo);
            check("err_addr", err_addr, m_ea);
            check("err_onehot", err_onehot, m_eh);
            check("rx_count", rx_count, m_rx);
        end
    end

    initial begin
        chk_en = 1'b1;
        // Reset state
        drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b0);
        drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b0);
        check("lit_reset_valid", out_valid, 0);
        check("lit_reset_rx", rx_count, 0);
        check("lit_reset_credit", in_vc_credit_gnt, 0);

        // Single packet
        drive(2'b01, 2'd0, 8'hA5, 1'b1, 1'b1);
        check("lit_single_valid", out_valid, 1);
        check("lit_single_vc", out_vc, 0);
        check("lit_single_data", out_data, 8'hA5);
        check("lit_single_rx", rx_count, 1);
        check("lit_single_erraddr", err_addr, 0);
        drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b1);
        check("lit_single_credit", in_vc_credit_gnt, 2'b01);
        check("lit_single_empty", out_valid, 0);

        // Fill VC 1 and overflow it
        for (int k = 0; k < 4; k++) drive(2'b10, 2'd0, 8'(8'h10 + k), 1'b0, 1'b1);
        check("lit_fill_overflow", err_overflow, 1);
        check("lit_fill_rx", rx_count, 4);
        for (int k = 0; k < 3; k++) begin
            check("lit_drain_vc", out_vc, 1);
            check("lit_drain_data", out_data, 8'h10 + k);
            drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b1);
            check("lit_drain_credit", in_vc_credit_gnt, 2'b10);
        end
        check("lit_drain_empty", out_valid, 0);

        // Round-robin across two preloaded VCs
        drive(2'b01, 2'd0, 8'hA0, 1'b0, 1'b1);
        drive(2'b10, 2'd0, 8'hB0, 1'b0, 1'b1);
        drive(2'b01, 2'd0, 8'hA1, 1'b0, 1'b1);
        drive(2'b10, 2'd0, 8'hB1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("lit_rr_vc", out_vc, k % 2);
            check("lit_rr_data", out_data, (k % 2) ? 8'hB0 + k / 2 : 8'hA0 + k / 2);
            drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b1);
        end

        // Stall stability: pointer moved to VC 1, yet VC 0 stays presented
        drive(2'b01, 2'd0, 8'h44, 1'b1, 1'b1);
        drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b1);
        drive(2'b01, 2'd0, 8'h55, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive((k == 0) ? 2'b10 : 2'b00, 2'd0, 8'h66, 1'b0, 1'b1);
            check("lit_stall_vc", out_vc, 0);
            check("lit_stall_data", out_data, 8'h55);
            check("lit_stall_credit", in_vc_credit_gnt, 0);
        end
        drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b1);
        check("lit_stall_next_vc", out_vc, 1);
        check("lit_stall_next_data", out_data, 8'h66);
        check("lit_stall_credit0", in_vc_credit_gnt, 2'b01);
        drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b1);
        check("lit_stall_credit1", in_vc_credit_gnt, 2'b10);

        // Error flags
        drive(2'b01, 2'(POSX ^ 1), 8'h77, 1'b1, 1'b1);
        check("lit_err_addr", err_addr, 1);
        check("lit_err_addr_stored", out_data, 8'h77);
        drive(2'b11, 2'd0, 8'h88, 1'b1, 1'b1);
        check("lit_err_onehot", err_onehot, 1);
        check("lit_err_onehot_rx", rx_count, 12);
        check("lit_err_onehot_empty", out_valid, 0);

        // Reset with packets buffered and a handshake pending
        drive(2'b01, 2'd0, 8'h91, 1'b0, 1'b1);
        drive(2'b10, 2'd0, 8'h92, 1'b0, 1'b1);
        check("lit_rst_pre_valid", out_valid, 1);
        drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b0);
        check("lit_rst_valid", out_valid, 0);
        check("lit_rst_rx", rx_count, 0);
        check("lit_rst_credit", in_vc_credit_gnt, 0);
        for (int k = 0; k < 2; k++) begin
            drive(2'b00, 2'd0, 8'h00, 1'b1, 1'b1);
            check("lit_post_rst_credit", in_vc_credit_gnt, 0);
        end

        // Random traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            logic [1:0] t, d;
            int p, rdy_pct;
            p = $urandom_range(0, 99);
            t = (p < 30) ? 2'b00 : (p < 60) ? 2'b01 : (p < 90) ? 2'b10 : 2'b11;
            d = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'(POSX);
            rdy_pct = (c < 1500) ? 4 : 8;
            drive(t, d, 8'($urandom), $urandom_range(0, 9) < rdy_pct,
                  $urandom_range(0, 199) != 0);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
